sink2: RTL

SINK2 -- requirements
Module: sink2

---
 rtl/sink2_pkg.sv | 11 +
 rtl/sink2_fifo.sv | 36 +++
 rtl/sink2.sv | 75 +++++++
 3 files changed

// File: rtl/sink2_pkg.sv
// sink2_pkg: shared state encoding, counter sizing and saturating add for sink2
package sink2_pkg;
  typedef enum logic {IDLE, PENDING} state_t;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SAT = 8'd255;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return (s > {1'b0, SAT}) ? SAT : s[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/sink2_fifo.sv
// sink2_fifo: circular receive buffer with extra-MSB pointers and registered storage
module sink2_fifo #(
  parameter int SIZE = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic [SIZE-1:0] head,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [SIZE-1:0] mem [DEPTH];
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // storage and pointers; contents cleared on reset so the head reads 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp[AW-1:0]] <= push_data;
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/sink2.sv
// sink2: two-phase req/ack flit sink with receive FIFO; optional payload checker under SINK2_CHECK_EN
module sink2
  import sink2_pkg::*;
#(
  parameter int ID = 0,
  parameter int SIZE = 8,
  parameter int DEPTH = 4,
  parameter int EXPECTED = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SIZE-1:0]  data,
  output logic             ack,
  output logic [SIZE-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] flits_rx,
  output logic [CNT_W-1:0] err_count
);
  state_t state, next_state;
  logic req_old, new_req, full, empty, pop, space, push, viol;
  assign new_req = req ^ req_old;
  assign out_valid = !empty;
  assign pop = out_ready && !empty;
  assign space = !full || pop;
  sink2_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .push_data(data),
    .pop(pop), .head(out_data), .full(full), .empty(empty)
  );
  // handshake FSM: accept immediately when there is room, otherwise park in PENDING
  always_comb begin
    next_state = state;
    push = 1'b0;
    viol = 1'b0;
    if (state == IDLE) begin
      push = new_req && space;
      next_state = (new_req && !space) ? PENDING : IDLE;
    end else begin
      push = space;
      viol = new_req;
      next_state = space ? IDLE : PENDING;
    end
  end
  // state, edge detector, ack toggle and accepted-flit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req_old <= 1'b0;
      ack <= 1'b0;
      flits_rx <= '0;
    end else begin
      state <= next_state;
      req_old <= req;
      ack <= ack ^ push;
      flits_rx <= sat_add(flits_rx, {1'b0, push});
    end
  end
`ifdef SINK2_CHECK_EN
  logic bad_data;
  assign bad_data = push && (data != SIZE'(EXPECTED));
  // payload mismatches and protocol violations can both land on one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count <= '0;
    else begin
      err_count <= sat_add(err_count, {1'b0, bad_data} + {1'b0, viol});
      if (bad_data) $display("sink2[%0d] t=%0t received %0h", ID, $time, data);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ID, EXPECTED, viol};
  assign err_count = '0;
`endif
endmodule
